alu_uart_probe: RTL

UART-driven ALU characterisation probe, sitting between `uart_hs` and the seven-segment/debug outputs on the bring-up board. It decodes two-byte command frames from the host, loads two DATA_W-bit operands byte-serially, and executes one selectable ALU operation per step command. It keeps registered ZF/CF/SF/OF flags and streams the result and flags back over UART on request. It succeeds the fixed 8-bit subtract-only harness with parametrised width, eight operations, carry-chained ops and readback.

---
 rtl/alu_probe_pkg.sv | 24 ++
 rtl/alu_probe_core.sv | 57 +++++
 rtl/alu_uart_probe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_probe_pkg.sv
// alu_probe_pkg: op codes, command bytes, flag bit indices and FSM states shared by the ALU probe
package alu_probe_pkg;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL1, OP_ADC, OP_SBB
   } op_e;

   typedef enum logic [2:0] {
      S_RX_CMD, S_RX_DATA, S_EXEC, S_TX_LOAD, S_TX_GAP, S_TX_WAIT
   } state_e;

   localparam logic [7:0] CMD_CLR  = 8'hE0;
   localparam logic [7:0] CMD_EXEC = 8'hE1;
   localparam logic [7:0] CMD_LDA  = 8'hE2;
   localparam logic [7:0] CMD_LDB  = 8'hE3;
   localparam logic [7:0] CMD_OPS  = 8'hE4;
   localparam logic [7:0] CMD_READ = 8'hE5;

   localparam int F_OF = 3;
   localparam int F_SF = 2;
   localparam int F_CF = 1;
   localparam int F_ZF = 0;

endpackage

// File: rtl/alu_probe_core.sv
// alu_probe_core: combinational ALU producing result and next {OF,SF,CF,ZF}; ADC/SBB only with ALU_PROBE_CARRY_EN, else ops 6/7 pass a
module alu_probe_core
   import alu_probe_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   input  logic              cin,
   output logic [DATA_W-1:0] y,
   output logic [3:0]        flags
);

   localparam int M = DATA_W - 1;

   logic [DATA_W:0] w_a, w_b, w_wide;
   logic            w_add, w_sub, w_of;

   assign w_a = {1'b0, a};
   assign w_b = {1'b0, b};

`ifdef ALU_PROBE_CARRY_EN
   logic [DATA_W:0] w_cin;
   assign w_cin = {{DATA_W{1'b0}}, cin};
   assign w_add = op == OP_ADD || op == OP_ADC;
   assign w_sub = op == OP_SUB || op == OP_SBB;
`else
   logic w_cin_unused;
   assign w_cin_unused = cin;
   assign w_add = op == OP_ADD;
   assign w_sub = op == OP_SUB;
`endif

   // Extra top bit carries the carry/borrow for arithmetic and the shifted-out bit for SHL1
   always_comb begin
      w_wide = w_a;
      case (op_e'(op))
         OP_ADD:  w_wide = w_a + w_b;
         OP_SUB:  w_wide = w_a - w_b;
         OP_AND:  w_wide = w_a & w_b;
         OP_OR:   w_wide = w_a | w_b;
         OP_XOR:  w_wide = w_a ^ w_b;
         OP_SHL1: w_wide = {a, 1'b0};
`ifdef ALU_PROBE_CARRY_EN
         OP_ADC:  w_wide = w_a + w_b + w_cin;
         OP_SBB:  w_wide = w_a - w_b - w_cin;
`endif
         default: w_wide = w_a;
      endcase
   end

   assign y     = w_wide[M:0];
   assign w_of  = ((w_add && a[M] == b[M]) || (w_sub && a[M] != b[M])) && y[M] != a[M];
   assign flags = {w_of, y[M], w_wide[DATA_W], y == '0};

endmodule

// File: rtl/alu_uart_probe.sv
// alu_uart_probe: UART command decoder, operand/flag registers and result readback around alu_probe_core (carry ops: ALU_PROBE_CARRY_EN)
module alu_uart_probe
   import alu_probe_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              uart_rec,
   input  logic [7:0]        uart_data_out,
   input  logic              uart_tx_busy,
   output logic              uart_send,
   output logic [7:0]        uart_data_in,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags,
   output logic [2:0]        op_sel,
   output logic              busy
);

   localparam logic [2:0] NB = 3'(DATA_W / 8 + 1);

   state_e              r_state, w_next;
   logic [7:0]          r_cmd;
   logic [DATA_W-1:0]   r_op_a, r_op_b, r_result, w_y;
   logic [3:0]          r_flags, w_flags;
   logic [2:0]          r_op_sel, r_left;
   logic [DATA_W+7:0]   r_snap;
   logic                w_rx_cmd, w_rx_data, w_tx_next;

   assign w_rx_cmd  = r_state == S_RX_CMD && uart_rec && uart_data_out != 8'h00;
   assign w_rx_data = r_state == S_RX_DATA && uart_rec;
   assign w_tx_next = r_state == S_TX_WAIT && !uart_tx_busy;

   alu_probe_core #(.DATA_W(DATA_W)) u_core (
      .a     (r_op_a),
      .b     (r_op_b),
      .op    (r_op_sel),
      .cin   (r_flags[F_CF]),
      .y     (w_y),
      .flags (w_flags)
   );

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) r_state <= S_RX_CMD;
      else            r_state <= w_next;

   // Next state and UART/busy outputs; bytes arriving outside RX states fall through unobserved
   always_comb begin
      w_next       = r_state;
      uart_send    = 1'b0;
      uart_data_in = 8'h00;
      busy         = 1'b1;
      case (r_state)
         S_RX_CMD: begin
            busy = 1'b0;
            if (w_rx_cmd) w_next = S_RX_DATA;
         end
         S_RX_DATA: begin
            busy = 1'b0;
            if (uart_rec) w_next = r_cmd == CMD_EXEC ? S_EXEC : r_cmd == CMD_READ ? S_TX_LOAD : S_RX_CMD;
         end
         S_EXEC:    w_next = S_RX_CMD;
         S_TX_LOAD: begin
            uart_send    = 1'b1;
            uart_data_in = r_snap[DATA_W+7 -: 8];
            w_next       = S_TX_GAP;
         end
         S_TX_GAP:  w_next = S_TX_WAIT;
         S_TX_WAIT: if (!uart_tx_busy) w_next = r_left == 3'd1 ? S_RX_CMD : S_TX_LOAD;
         default:   w_next = S_RX_CMD;
      endcase
   end

   // Command latch, operand loads and ALU result/flag capture at the end of EXEC
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_cmd    <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_op_sel <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         if (w_rx_cmd) r_cmd <= uart_data_out;
         if (w_rx_data && r_cmd == CMD_LDA) r_op_a <= DATA_W'({r_op_a, uart_data_out});
         if (w_rx_data && r_cmd == CMD_LDB) r_op_b <= DATA_W'({r_op_b, uart_data_out});
         if (w_rx_data && r_cmd == CMD_OPS) r_op_sel <= uart_data_out[2:0];
         if (w_rx_data && r_cmd == CMD_CLR) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_flags  <= '0;
         end
         if (r_state == S_EXEC) begin
            r_result <= w_y;
            r_flags  <= w_flags;
         end
      end

   // Readback snapshot: result bytes MSB first then the flag byte, shifted out one byte per send
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_snap <= '0;
         r_left <= '0;
      end else if (w_rx_data && r_cmd == CMD_READ) begin
         r_snap <= {r_result, 4'h0, r_flags};
         r_left <= NB;
      end else if (w_tx_next) begin
         r_snap <= r_snap << 8;
         r_left <= r_left - 3'd1;
      end

   assign op_a   = r_op_a;
   assign op_b   = r_op_b;
   assign result = r_result;
   assign flags  = r_flags;
   assign op_sel = r_op_sel;

endmodule
